// File: rtl/regfile_write_bank_if.sv
// Write/clear handshake and flat register readout bundle for regfile_write_bank.
// master = write requester, slave = register bank.
interface regfile_write_bank_if #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL       = 5
);
  logic                            wr_valid;
  logic [SEL-1:0]                  wr_addr;
  logic [BUS_WIDTH-1:0]            wr_data;
  logic                            wr_ready;
  logic                            clr_req;
  logic                            clr_busy;
  logic                            clr_done;
  logic [BUS_WIDTH*(2**SEL)-1:0]   Dout;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, clr_busy, clr_done, Dout
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, clr_busy, clr_done, Dout
  );
endinterface

// File: rtl/regfile_write_bank.sv
// Register-file write bank: 1-cycle write latency; wr_ready drops during the 2**SEL-cycle clear or on clr_req.
// REGFILE_ZERO_REG_EN makes register 0 read as constant zero (writes to it are accepted and discarded).
module regfile_write_bank #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_write_bank_if.slave  bus
);
  localparam int NREG = 2**SEL;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [SEL-1:0]       cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] regs_q [NREG];

  logic                 wr_ready;
  logic                 clr_busy;
  logic                 clr_done;
  logic                 wr_en;
  logic                 clr_en;
  logic [BUS_WIDTH*NREG-1:0] dout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ready = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    wr_en    = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = !bus.clr_req;
        if (bus.clr_req) begin
          // Clear wins over a coincident write request.
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          wr_en = bus.wr_valid;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_en   = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {SEL{1'b1}}) begin
          clr_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef REGFILE_ZERO_REG_EN
    // Register 0 never loads; it only ever sees reset/clear zeros.
    if (bus.wr_addr == '0) wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (clr_en) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NREG; i++) dout[i*BUS_WIDTH +: BUS_WIDTH] = regs_q[i];
  end

  assign bus.wr_ready = wr_ready;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;
  assign bus.Dout     = dout;
endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank with a per-cycle reference model.
module tb_regfile_write_bank;
  localparam int BW   = 32;
  localparam int SEL  = 5;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_write_bank_if #(.BUS_WIDTH(BW), .SEL(SEL)) bus ();
  regfile_write_bank #(.BUS_WIDTH(BW), .SEL(SEL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;
  int dut_acc = 0;
  int done_seen = 0;
  bit check_en = 1'b0;

  // Reference model: register contents plus number of clear cycles still owed.
  logic [BW-1:0] mdl [NREG];
  int clr_left = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dout(input string name);
    logic [BW-1:0] got;
    logic [BW-1:0] bad_got;
    int bad;
    bad = -1;
    bad_got = '0;
    for (int i = 0; i < NREG; i++) begin
      got = bus.Dout[i*BW +: BW];
      if (got !== mdl[i] && bad < 0) begin
        bad = i;
        bad_got = got;
      end
    end
    nchk++;
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s: slice %0d got %h expected %h at %0t", name, bad, bad_got, mdl[bad], $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      mdl[NREG - clr_left] = '0;
      clr_left = clr_left - 1;
    end else if (bus.clr_req) begin
      clr_left = NREG;
    end else if (bus.wr_valid) begin
`ifdef REGFILE_ZERO_REG_EN
      if (bus.wr_addr != '0) mdl[bus.wr_addr] = bus.wr_data;
`else
      mdl[bus.wr_addr] = bus.wr_data;
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_wr_ready", {31'd0, bus.wr_ready}, {31'd0, (clr_left == 0) && !bus.clr_req});
      chk("cyc_clr_busy", {31'd0, bus.clr_busy}, {31'd0, clr_left > 0});
      chk("cyc_clr_done", {31'd0, bus.clr_done}, {31'd0, clr_left == 1});
      chk_dout("cyc_dout");
      if (bus.clr_done) done_seen++;
    end
  end

  // Inputs change 1 time unit after a rising edge; handshakes are counted at the negedge before the edge.
  task automatic step();
    @(negedge clk);
    if (bus.wr_valid && bus.wr_ready) dut_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [SEL-1:0] a, input logic [BW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, busy_cnt, done_cnt, done_at, guard, d0;
    logic [BW-1:0] exp0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.clr_req  = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.clr_done}, 32'd0);
    chk("rst_dout_any", {31'd0, |bus.Dout}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    wr(5'd5, 32'hDEADBEEF);
    chk("wr1_slice5", bus.Dout[5*BW +: BW], 32'hDEADBEEF);
    chk("wr1_slice4", bus.Dout[4*BW +: BW], 32'h0);
    chk("wr1_slice6", bus.Dout[6*BW +: BW], 32'h0);

    a0 = dut_acc;
    for (int i = 0; i < NREG; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = SEL'(i);
      bus.wr_data  = 32'h100 + BW'(i);
      step();
    end
    bus.wr_valid = 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    exp0 = 32'h0;
`else
    exp0 = 32'h100;
`endif
    chk("b2b_accepts", BW'(dut_acc - a0), 32'd32);
    chk("b2b_slice0", bus.Dout[0 +: BW], exp0);
    chk("b2b_slice5", bus.Dout[5*BW +: BW], 32'h105);
    chk("b2b_slice31", bus.Dout[31*BW +: BW], 32'h11F);

    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd3;
    bus.wr_data  = 32'h1234;
    #1;
    chk("clrw_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    a0 = dut_acc;
    step();
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; guard = 0;
    while (bus.clr_busy && guard < 40) begin
      busy_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      step();
      guard++;
    end
    chk("clrw_no_accept", BW'(dut_acc - a0), 32'd0);
    chk("clrw_busy_cycles", BW'(busy_cnt), 32'd32);
    chk("clrw_done_pulses", BW'(done_cnt), 32'd1);
    chk("clrw_done_at", BW'(done_at), 32'd32);
    chk("clrw_slice3", bus.Dout[3*BW +: BW], 32'h0);
    chk("clrw_dout_any", {31'd0, |bus.Dout}, 32'd0);

    wr(5'd9, 32'h99);
    bus.clr_req = 1'b1;
    repeat (33) step();
    chk("hold_idle_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("hold_idle_ready", {31'd0, bus.wr_ready}, 32'd0);
    step();
    chk("hold_restart", {31'd0, bus.clr_busy}, 32'd1);
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd12;
    bus.wr_data  = 32'hCAFE;
    guard = 0;
    while (bus.clr_busy && guard < 40) begin
      step();
      guard++;
    end
    chk("hold_drain", {31'd0, bus.clr_busy}, 32'd0);
    step();
    bus.wr_valid = 1'b0;
    chk("hold_slice12", bus.Dout[12*BW +: BW], 32'hCAFE);
    chk("hold_slice9", bus.Dout[9*BW +: BW], 32'h0);

    wr(5'd7, 32'hA5A5A5A5);
    wr(5'd31, 32'h5A5A5A5A);
    wr(5'd2, 32'h77);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (10) step();
    chk("mid_busy", {31'd0, bus.clr_busy}, 32'd1);
    chk("mid_slice31_kept", bus.Dout[31*BW +: BW], 32'h5A5A5A5A);
    d0 = done_seen;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.clr_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("mid_rst_dout_any", {31'd0, |bus.Dout}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_no_done", BW'(done_seen - d0), 32'd0);
    chk("mid_idle", {31'd0, bus.clr_busy}, 32'd0);

    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'hFFFFFFFF;
    #1;
    chk("z_ready", {31'd0, bus.wr_ready}, 32'd1);
    a0 = dut_acc;
    step();
    bus.wr_valid = 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    exp0 = 32'h0;
`else
    exp0 = 32'hFFFFFFFF;
`endif
    chk("z_accept", BW'(dut_acc - a0), 32'd1);
    chk("z_slice0", bus.Dout[0 +: BW], exp0);
    wr(5'd1, 32'h11111111);
    chk("z_slice1", bus.Dout[1*BW +: BW], 32'h11111111);

    step();
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the register file: demultiplexes one BUS_WIDTH write word into one of 2**SEL registers.
- Exposes every register on one flat bus. That bus feeds the 32-to-1 read multiplexer's Din directly: same packing, same parameters.
- Adds a valid/ready write handshake and a sequential bulk-clear engine that zeroes one register per cycle.

Parameters:
- BUS_WIDTH, 32, bits per register.
- SEL, 5, address bits; number of registers is 2**SEL.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request present.
- wr_addr  input  SEL  target register index.
- wr_data  input  BUS_WIDTH  word to write.
- wr_ready  output  1  write can be accepted this cycle.
- clr_req  input  1  request to zero all registers.
- clr_busy  output  1  clear sequence in progress.
- clr_done  output  1  one-cycle pulse on the final clear cycle.
- Dout  output  BUS_WIDTH*(2**SEL)  all registers; register i occupies Dout[i*BUS_WIDTH +: BUS_WIDTH].

Behaviour:
- Reset (async, rst=1):
  - all registers 0; state IDLE; clear counter 0.
  - clr_busy=0, clr_done=0.
  - wr_ready follows its combinational rule (1 when clr_req=0).
- States:
  - IDLE: clr_busy=0.
  - CLEAR: clr_busy=1, wr_ready=0.
- wr_ready = (state==IDLE) && !clr_req. Combinational; no dependence on wr_valid.
- Write accept:
  - A write is accepted at a rising edge where wr_valid && wr_ready.
  - reg[wr_addr] <= wr_data at that edge. Visible on Dout the next cycle (latency 1).
  - Exactly one register changes per accepted write; all others hold.
- wr_valid while wr_ready=0: ignored, no state change. The requester holds wr_valid/addr/data until ready.
- IDLE -> CLEAR:
  - At an edge with clr_req=1 in IDLE, counter <= 0.
  - No register is written on that edge, even if wr_valid=1; clear has priority.
- CLEAR sequence:
  - Each cycle: reg[counter] <= 0, then counter increments.
  - When counter == 2**SEL-1: that register is zeroed, clr_done=1 for this cycle only, state -> IDLE, counter -> 0.
  - Total clear occupancy: 2**SEL cycles (32 at default) after the request edge.
- clr_req asserted during CLEAR: ignored. A still-asserted clr_req in the first IDLE cycle starts a new clear.
- Counter wraps naturally at SEL bits; no out-of-range index is possible.
- Reset mid-clear: aborts immediately to the reset values; no clr_done.
- Dout is purely the register contents: no combinational path from wr_data or wr_addr.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired 0, and Dout[BUS_WIDTH-1:0] is constant 0.
  - Writes with wr_addr==0 are still accepted (handshake completes) but discarded.
  - The clear sequence is unchanged: 2**SEL cycles.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset then idle: rst pulse -> Dout all 0, wr_ready=1, clr_busy=0, clr_done=0.
- Single write: wr_valid=1, wr_addr=5, wr_data=0xDEADBEEF for one edge -> next cycle Dout[5*32 +: 32]=0xDEADBEEF, all other slices 0.
- Back-to-back writes: addresses 0..31 with data 0x100+i on consecutive cycles -> each slice i holds 0x100+i; 32 accepts in 32 cycles.
- Simultaneous clear and write:
  - Stimulus: clr_req=1 with wr_valid=1, wr_addr=3, wr_data=0x1234.
  - Required: wr_ready=0; write dropped; clr_busy=1 for 32 cycles; clr_done pulses once on the 32nd; all registers 0 afterwards.
- Reset mid-clear: preload registers, start clear, assert rst after 10 clear cycles -> all registers 0, state IDLE, no clr_done pulse.
- With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to address 0 -> handshake completes, slice 0 stays 0; write to address 1 -> stored normally.
